// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width and transmit-queue FSM encoding
package uart_pkg;
    localparam int UART_BYTE_W = 8;
    typedef enum logic [1:0] {TXQ_IDLE, TXQ_ARM, TXQ_DRAIN} txq_state_e;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: single-clock byte FIFO with combinational read head and synchronous flush
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [UART_BYTE_W-1:0] wdata,
    output logic [UART_BYTE_W-1:0] rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [UART_BYTE_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]          r_wr;
    logic [PW-1:0]          r_rd;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= push ? r_wr + PW'(1) : r_wr;
            r_rd <= flush ? r_wr : (pop ? r_rd + PW'(1) : r_rd);
        end
    end
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr[AW-1:0]] <= wdata;
    end
    // Extra pointer MSB makes wr-rd span 0..DEPTH without ambiguity
    assign rdata = r_mem[r_rd[AW-1:0]];
    assign level = r_wr - r_rd;
    assign full  = level == PW'(DEPTH);
    assign empty = level == '0;
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffers producer bytes and paces them into the transmitter
// on its start/busy handshake, flagging bytes whose busy never rises.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [UART_BYTE_W-1:0] in_data,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   tx_start,
    output logic [UART_BYTE_W-1:0] tx_data,
    input  logic                   tx_busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   err_timeout
);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    txq_state_e             r_state;
    txq_state_e             w_state_nxt;
    logic [UART_BYTE_W-1:0] w_head;
    logic [UART_BYTE_W-1:0] r_tx_data;
    logic                   r_tx_start;
    logic                   r_err;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_inc;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_timeout;
    assign in_ready    = !full && !flush && !rst;
    assign w_push      = in_valid && in_ready;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign err_timeout = r_err;
    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (flush),
        .wdata (in_data),
        .rdata (w_head),
        .level (level),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= TXQ_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= w_pop;
            r_tx_data  <= w_pop ? w_head : r_tx_data;
            r_cnt      <= w_pop ? '0 : (r_state == TXQ_ARM ? w_cnt_inc : r_cnt);
            r_err      <= r_err || w_timeout;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TXQ_IDLE:  w_state_nxt = w_pop ? TXQ_ARM : TXQ_IDLE;
            TXQ_ARM:   w_state_nxt = tx_busy ? TXQ_DRAIN : (w_timeout ? TXQ_IDLE : TXQ_ARM);
            TXQ_DRAIN: w_state_nxt = tx_busy ? TXQ_DRAIN : TXQ_IDLE;
            default:   w_state_nxt = TXQ_IDLE;
        endcase
    end
    // Flush outranks a pop so a discarded head is never launched
    always_comb begin
        w_cnt_inc = r_cnt + CW'(1);
        w_pop     = (r_state == TXQ_IDLE) && !empty && !tx_busy && !flush;
        w_timeout = (r_state == TXQ_ARM) && !tx_busy && (w_cnt_inc == CW'(BUSY_TIMEOUT));
    end
endmodule
